// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared definitions for the delay-sweep sequencer:
//   SWEEP_DW - default width of delay, step and point/shot counters
//   state_t  - 3-bit sequencer state encoding
// -----------------------------------------------------------------------------
package sweep_pkg;

  localparam int SWEEP_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage : sweep_pkg

// File: rtl/sweep_counter.sv
// -----------------------------------------------------------------------------
// sweep_counter
// Up-counter with clear, increment and end-of-count detection. Used once for
// shots within a point and once for points within a sweep.
//
// Ports:
//   clk_pll  in   clock, rising edge
//   reset    in   synchronous, active-low reset
//   clr_i    in   clear count to zero (wins over inc_i)
//   inc_i    in   increment count by one
//   limit_i  in   terminal count; last_o flags count == limit_i - 1
//   count_o  out  registered count value
//   last_o   out  count has reached its final value for this limit
// -----------------------------------------------------------------------------
module sweep_counter
  import sweep_pkg::*;
#(
  parameter int DW = SWEEP_DW
) (
  input  logic          clk_pll,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [DW-1:0] limit_i,
  output logic [DW-1:0] count_o,
  output logic          last_o
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] count_q;
  logic [DW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit never reaches RUN, so the wrapped limit-1 is harmless.
  assign last_o  = (count_q == (limit_i - ONE));
  assign count_o = count_q;

endmodule : sweep_counter

// File: rtl/sweep_sequencer.sv
// -----------------------------------------------------------------------------
// sweep_sequencer
// Steps a pulse generator through a series of delay points. Each point loads
// a new delay (xfer strobe), throws away the first, partial period, then
// counts cfg_shots full periods before moving on with del += step.
//
// Ports:
//   clk_pll     in   200 MHz clock, rising edge
//   reset       in   synchronous, active-low reset
//   start       in   one-cycle sweep request (accepted in IDLE/DONE only)
//   abort       in   one-cycle stop request, highest priority
//   cfg_del0    in   delay of point 0 (clock cycles)
//   cfg_step    in   delay increment per point
//   cfg_points  in   number of points
//   cfg_shots   in   counted periods per point
//   shot_end    in   period-wrap pulse from the pulse generator
//   del         out  delay presented to the pulse generator
//   xfer        out  one-cycle parameter-load strobe
//   busy        out  sweep in progress (LOAD/ARM/RUN)
//   done        out  sweep finished, held until next accepted start
//   point       out  current point index
//   shot        out  completed shots at the current point
//   sat         out  sticky: a delay increment saturated
// -----------------------------------------------------------------------------
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int DW = SWEEP_DW
) (
  input  logic          clk_pll,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_del0,
  input  logic [DW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_points,
  input  logic [DW-1:0] cfg_shots,
  input  logic          shot_end,
  output logic [DW-1:0] del,
  output logic          xfer,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] point,
  output logic [DW-1:0] shot,
  output logic          sat
);

  state_t        state_q,  state_d;
  logic [DW-1:0] del_q,    del_d;
  logic          xfer_q,   xfer_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          sat_q,    sat_d;
  // cfg_del0 goes straight into del_q at start, so only these three are kept.
  logic [DW-1:0] step_q,   step_d;
  logic [DW-1:0] points_q, points_d;
  logic [DW-1:0] shots_q,  shots_d;

  logic          shot_clr, shot_inc, shot_last;
  logic          pt_clr,   pt_inc,   pt_last;
  logic [DW-1:0] shot_cnt, pt_cnt;

  // One extra bit so a wrap of the delay is visible as a carry.
  logic [DW:0]   del_sum;
  assign del_sum = {1'b0, del_q} + {1'b0, step_q};

  sweep_counter #(.DW(DW)) u_shot_cnt (
    .clk_pll (clk_pll),
    .reset   (reset),
    .clr_i   (shot_clr),
    .inc_i   (shot_inc),
    .limit_i (shots_q),
    .count_o (shot_cnt),
    .last_o  (shot_last)
  );

  sweep_counter #(.DW(DW)) u_point_cnt (
    .clk_pll (clk_pll),
    .reset   (reset),
    .clr_i   (pt_clr),
    .inc_i   (pt_inc),
    .limit_i (points_q),
    .count_o (pt_cnt),
    .last_o  (pt_last)
  );

  always_comb begin
    state_d  = state_q;
    del_d    = del_q;
    sat_d    = sat_q;
    step_d   = step_q;
    points_d = points_q;
    shots_d  = shots_q;
    shot_clr = 1'b0;
    shot_inc = 1'b0;
    pt_clr   = 1'b0;
    pt_inc   = 1'b0;

    if (abort) begin
      // Counters and delay freeze where they are; only the state unwinds.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            step_d   = cfg_step;
            points_d = cfg_points;
            shots_d  = cfg_shots;
            sat_d    = 1'b0;
            shot_clr = 1'b1;
            pt_clr   = 1'b1;
            if ((cfg_points == '0) || (cfg_shots == '0)) begin
              // Empty sweep: finish at once and leave the generator alone.
              state_d = ST_DONE;
            end else begin
              del_d   = cfg_del0;
              state_d = ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          state_d = ST_ARM;
        end

        ST_ARM: begin
          // First wrap after a load ends a partial period; do not count it.
          if (shot_end) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (shot_end) begin
            if (shot_last) begin
              shot_clr = 1'b1;
              if (pt_last) begin
                state_d = ST_DONE;
              end else begin
                pt_inc  = 1'b1;
                state_d = ST_LOAD;
                if (del_sum[DW]) begin
                  del_d = '1;
                  sat_d = 1'b1;
                end else begin
                  del_d = del_sum[DW-1:0];
                end
              end
            end else begin
              shot_inc = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // The strobe lags LOAD by one cycle so del has already been stable for a
    // full cycle when xfer rises.
    xfer_d = (state_q == ST_LOAD) && !abort;
    busy_d = (state_d == ST_LOAD) || (state_d == ST_ARM) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      del_q    <= '0;
      xfer_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      step_q   <= '0;
      points_q <= '0;
      shots_q  <= '0;
    end else begin
      state_q  <= state_d;
      del_q    <= del_d;
      xfer_q   <= xfer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      step_q   <= step_d;
      points_q <= points_d;
      shots_q  <= shots_d;
    end
  end

  assign del   = del_q;
  assign xfer  = xfer_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sat   = sat_q;
  assign point = pt_cnt;
  assign shot  = shot_cnt;

endmodule : sweep_sequencer

// File: tb/tb_sweep_sequencer.sv
module tb_sweep_sequencer;

  localparam int DW = 16;

  logic          clk_pll = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] cfg_del0 = '0;
  logic [DW-1:0] cfg_step = '0;
  logic [DW-1:0] cfg_points = '0;
  logic [DW-1:0] cfg_shots = '0;
  logic          shot_end;
  logic [DW-1:0] del;
  logic          xfer;
  logic          busy;
  logic          done;
  logic [DW-1:0] point;
  logic [DW-1:0] shot;
  logic          sat;

  logic          gen_pulse = 1'b0;
  logic          man_pulse = 1'b0;
  logic          se_en = 1'b0;
  int            gen_cnt = 0;

  assign shot_end = gen_pulse | man_pulse;

  always #5 clk_pll = ~clk_pll;

  sweep_sequencer #(.DW(DW)) dut (
    .clk_pll    (clk_pll),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_del0   (cfg_del0),
    .cfg_step   (cfg_step),
    .cfg_points (cfg_points),
    .cfg_shots  (cfg_shots),
    .shot_end   (shot_end),
    .del        (del),
    .xfer       (xfer),
    .busy       (busy),
    .done       (done),
    .point      (point),
    .shot       (shot),
    .sat        (sat)
  );

  // Free-running pulse generator model: one shot_end every 20 cycles.
  always @(posedge clk_pll) begin
    if (!se_en) begin
      gen_cnt   <= 0;
      gen_pulse <= 1'b0;
    end else if (gen_cnt == 19) begin
      gen_cnt   <= 0;
      gen_pulse <= 1'b1;
    end else begin
      gen_cnt   <= gen_cnt + 1;
      gen_pulse <= 1'b0;
    end
  end

  typedef struct packed {
    logic [DW-1:0] del;
    logic          sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   se_busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every xfer must match the next queued expectation.
  always @(negedge clk_pll) begin
    if (shot_end === 1'b1 && busy === 1'b1) se_busy_cnt++;
    if (xfer === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got xfer with del=%0h, required no xfer", del);
      end else begin
        mon_e = exp_q.pop_front();
        $display("xfer del=%0h sat=%0b (expected del=%0h sat=%0b)", del, sat, mon_e.del, mon_e.sat);
        chk("xfer_del", del, mon_e.del);
        chk("xfer_sat", sat, mon_e.sat);
      end
    end
  end

  task automatic tick;
    @(posedge clk_pll);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic man_shot(input int gap);
    repeat (gap) tick();
    man_pulse = 1'b1;
    tick();
    man_pulse = 1'b0;
  endtask

  task automatic set_cfg(input logic [DW-1:0] d0, input logic [DW-1:0] st,
                         input logic [DW-1:0] pts, input logic [DW-1:0] sh);
    cfg_del0   = d0;
    cfg_step   = st;
    cfg_points = pts;
    cfg_shots  = sh;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic s);
    exp_t e;
    e.del = d;
    e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int limit, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_pll);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  // Three-point sweep from 200 by 10, two shots per point. With perturb set,
  // a second start and a new cfg_step arrive mid-sweep and must be ignored.
  task automatic sweep_200(input bit perturb);
    int base;
    set_cfg(16'd200, 16'd10, 16'd3, 16'd2);
    push(16'd200, 1'b0);
    push(16'd210, 1'b0);
    push(16'd220, 1'b0);
    base = se_busy_cnt;
    pulse_start();
    @(negedge clk_pll);
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_xfer_low", {31'd0, xfer}, 32'd0);
    @(negedge clk_pll);
    chk("xfer_rise", {31'd0, xfer}, 32'd1);
    tick();
    se_en = 1'b1;
    if (perturb) begin
      repeat (30) tick();
      cfg_step   = 16'd55;
      cfg_points = 16'd7;
      pulse_start();
      @(negedge clk_pll);
      chk("restart_ignored_busy", {31'd0, busy}, 32'd1);
    end
    wait_done(400, "sweep_done_timeout");
    se_en = 1'b0;
    chk("sweep_busy", {31'd0, busy}, 32'd0);
    chk("sweep_point", point, 32'd2);
    chk("sweep_shot", shot, 32'd0);
    chk("sweep_del", del, 32'd220);
    chk("sweep_shot_ends", se_busy_cnt - base, 32'd9);
    chk("sweep_queue_empty", exp_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk_pll);
    chk("rst_del", del, 32'd0);
    chk("rst_xfer", {31'd0, xfer}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_point", point, 32'd0);
    chk("rst_shot", shot, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic sweep, then same sweep with mid-sweep start and cfg changes
    sweep_200(1'b0);
    sweep_200(1'b1);

    // Empty sweep: no xfer, done next cycle, del untouched
    set_cfg(16'd7, 16'd3, 16'd0, 16'd5);
    pulse_start();
    @(negedge clk_pll);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_busy", {31'd0, busy}, 32'd0);
    chk("empty_del", del, 32'd220);
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk_pll);
      chk("empty_busy_hold", {31'd0, busy}, 32'd0);
    end
    tick();
    set_cfg(16'd7, 16'd3, 16'd4, 16'd0);
    pulse_start();
    @(negedge clk_pll);
    chk("noshot_done", {31'd0, done}, 32'd1);
    chk("noshot_busy", {31'd0, busy}, 32'd0);
    tick();

    // Saturating delay increment
    set_cfg(16'hFFF0, 16'h0020, 16'd2, 16'd1);
    push(16'hFFF0, 1'b0);
    push(16'hFFFF, 1'b1);
    pulse_start();
    tick();
    se_en = 1'b1;
    wait_done(200, "sat_done_timeout");
    se_en = 1'b0;
    chk("sat_del", del, 32'hFFFF);
    chk("sat_flag", {31'd0, sat}, 32'd1);
    chk("sat_point", point, 32'd1);
    chk("sat_queue_empty", exp_q.size(), 32'd0);
    repeat (2) tick();

    // Abort coinciding with shot_end in RUN at point 1, shot 0
    set_cfg(16'd100, 16'd5, 16'd3, 16'd2);
    push(16'd100, 1'b0);
    push(16'd105, 1'b0);
    pulse_start();
    man_shot(3);  // discarded
    man_shot(2);  // shot 1
    man_shot(2);  // end of point 0
    man_shot(3);  // discarded at point 1
    @(negedge clk_pll);
    chk("pre_abort_point", point, 32'd1);
    chk("pre_abort_shot", shot, 32'd0);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    tick();
    abort     = 1'b1;
    man_pulse = 1'b1;
    tick();
    abort     = 1'b0;
    man_pulse = 1'b0;
    @(negedge clk_pll);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_shot", shot, 32'd0);
    chk("abort_point", point, 32'd1);
    chk("abort_del", del, 32'd105);
    repeat (10) tick();
    chk("abort_queue_empty", exp_q.size(), 32'd0);
    set_cfg(16'd100, 16'd5, 16'd1, 16'd1);
    push(16'd100, 1'b0);
    pulse_start();
    man_shot(3);
    man_shot(3);
    wait_done(20, "restart_done_timeout");
    chk("restart_del", del, 32'd100);
    chk("restart_point", point, 32'd0);
    tick();

    // Reset while in ARM
    set_cfg(16'd300, 16'd1, 16'd2, 16'd2);
    push(16'd300, 1'b0);
    pulse_start();
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_pll);
        if (xfer === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      chk("arm_xfer_timeout", {31'd0, seen}, 32'd1);
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk_pll);
    chk("armrst_del", del, 32'd0);
    chk("armrst_xfer", {31'd0, xfer}, 32'd0);
    chk("armrst_busy", {31'd0, busy}, 32'd0);
    chk("armrst_done", {31'd0, done}, 32'd0);
    chk("armrst_point", point, 32'd0);
    chk("armrst_shot", shot, 32'd0);
    chk("armrst_sat", {31'd0, sat}, 32'd0);
    reset = 1'b1;
    man_shot(2);
    repeat (10) tick();
    @(negedge clk_pll);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sweep_sequencer

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16: width of delay value, step value and point/shot counters.
REQ-002 SHALL have port clk_pll  input  1  200 MHz PLL clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  one-cycle request to stop the sweep immediately.
REQ-006 SHALL have port cfg_del0  input  DW  delay value for point 0, in clock cycles.
REQ-007 SHALL have port cfg_step  input  DW  delay increment per point.
REQ-008 SHALL have port cfg_points  input  DW  number of sweep points.
REQ-009 SHALL have port cfg_shots  input  DW  shots (pulse periods) per point.
REQ-010 SHALL have port shot_end  input  1  one-cycle pulse from the pulse generator at each period wrap.
REQ-011 SHALL have port del  output  DW  delay presented to the pulse generator.
REQ-012 SHALL have port xfer  output  1  one-cycle parameter-load strobe to the pulse generator.
REQ-013 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-014 SHALL have port done  output  1  level; high after sweep completion until the next accepted start.
REQ-015 SHALL have port point  output  DW  current point index.
REQ-016 SHALL have port shot  output  DW  completed shots at the current point.
REQ-017 SHALL have port sat  output  1  sticky flag: a delay increment saturated.

Function
REQ-018 SHALL implement states IDLE, LOAD, ARM, RUN and DONE; all outputs SHALL be registered.
REQ-019 SHALL accept start only in IDLE or DONE: latch all cfg_* values, set del=cfg_del0, point=0, shot=0, sat=0, done=0, and go to LOAD.
REQ-020 SHALL, on a start accepted with cfg_points==0 or cfg_shots==0, go directly to DONE with done=1, emit no xfer, and leave del unchanged.
REQ-021 SHALL, in LOAD, drive xfer=1 for exactly one cycle and go to ARM; xfer SHALL rise one cycle after start is accepted.
REQ-022 SHALL hold del stable from at least one cycle before xfer rises until the next point update.
REQ-023 SHALL, in ARM, discard the first shot_end (partial period) and go to RUN without counting it.
REQ-024 SHALL, in RUN, increment shot on each shot_end.
REQ-025 SHALL treat shot_end with shot==shots-1 in RUN as end of point: shot=0; if point==points-1, go to DONE with done=1 and busy=0; otherwise point+1, del=del+step, and go to LOAD.
REQ-026 SHALL compute del+step in DW+1 bits; on carry out, del SHALL saturate at all-ones and sat SHALL be set.
REQ-027 SHALL ignore shot_end in IDLE, LOAD and DONE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL ignore changes to cfg_* while busy=1; only the values latched at start apply.
REQ-030 SHALL give abort priority over start and shot_end in the same cycle: go to IDLE next cycle, busy=0, done=0, no xfer, with del, point and shot holding their values.
REQ-031 SHALL drive busy=1 exactly in LOAD, ARM and RUN.

Reset
REQ-032 SHALL, when reset==0 at a clock edge, enter IDLE with del=0, xfer=0, busy=0, done=0, point=0, shot=0, sat=0 and all latched cfg registers cleared.
REQ-033 SHALL, on reset mid-sweep, abandon the sweep with no xfer pulse emitted during or after reset.

Structure
REQ-034 SHALL take state encodings (3-bit) and the default DW from shared package sweep_pkg.
REQ-035 SHALL implement shot/point counting with end-of-count detection in one sub-module, sweep_counter, instantiated twice (shots, points).

Verification
REQ-036 SHALL verify: del0=200, step=10, points=3, shots=2, shot_end every 20 cycles -> xfer three times with del=200, 210, 220; each point spans 1 discarded + 2 counted shot_end; done=1 after the sixth counted shot.
REQ-037 SHALL verify: points=0, shots=5, start -> done=1 next cycle, xfer never asserted, busy stays 0.
REQ-038 SHALL verify: del0=16'hFFF0, step=16'h0020, points=2, shots=1 -> second xfer carries del=16'hFFFF and sat=1.
REQ-039 SHALL verify: abort and shot_end in the same cycle during RUN at point=1, shot=0 -> IDLE, busy=0, shot stays 0, no xfer; a later start restarts at del0.
REQ-040 SHALL verify: start pulsed again mid-sweep, and cfg_step changed mid-sweep -> no effect on the sequence of del values.
REQ-041 SHALL verify: reset=0 asserted during ARM -> all outputs return to their reset values on the next edge; no xfer.
